// File: rtl/vga_timing_gen_if.sv
// Pixel-scan bundle from the timing generator to renderers/muxes.
// Latency: n/a (wires only).  Backpressure: none, the scan is free-running.
interface vga_timing_gen_if;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        sof;
    logic        eol;
    logic [15:0] frame_count;

    modport master (
        output hs, vs, blank, DrawX, DrawY, sof, eol, frame_count
    );

    modport slave (
        input  hs, vs, blank, DrawX, DrawY, sof, eol, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster scan source (default 640x480@60, 800x525 total); optional VGA_TIMING_FRAME_COUNT_EN.
// Latency: outputs are registered decodes, one clock behind the hc/vc counters.
// Backpressure: none; the scan never stalls.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // 11-bit thresholds so a sync end equal to 1024 still compares correctly
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [10:0] hc_x;
    logic [10:0] vc_x;
    logic        line_end;
    logic        frame_end;

    assign hc_x      = {1'b0, hc};
    assign vc_x      = {1'b0, vc};
    assign line_end  = (hc == H_LAST);
    assign frame_end = line_end && (vc == V_LAST);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc <= 10'd0;
            vc <= 10'd0;
        end else if (line_end) begin
            hc <= 10'd0;
            vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    logic hs_d;
    logic vs_d;
    logic blank_d;
    logic sof_d;

    always_comb begin
        hs_d    = !((hc_x >= HS_START) && (hc_x < HS_END));
        vs_d    = !((vc_x >= VS_START) && (vc_x < VS_END));
        blank_d = (hc_x < H_VIS_END) && (vc_x < V_VIS_END);
        sof_d   = (hc == 10'd0) && (vc == 10'd0);
    end

    // DrawX/DrawY register alongside the decodes so every output describes one pixel
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vga.hs    <= 1'b1;
            vga.vs    <= 1'b1;
            vga.blank <= 1'b0;
            vga.DrawX <= 10'd0;
            vga.DrawY <= 10'd0;
            vga.sof   <= 1'b0;
            vga.eol   <= 1'b0;
        end else begin
            vga.hs    <= hs_d;
            vga.vs    <= vs_d;
            vga.blank <= blank_d;
            vga.DrawX <= hc;
            vga.DrawY <= vc;
            vga.sof   <= sof_d;
            vga.eol   <= line_end;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    // Wrap flag is delayed one clock so the count steps together with sof, not eol
    logic        wrap_q;
    logic [15:0] frame_cnt_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q      <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            wrap_q      <= frame_end;
            frame_cnt_q <= frame_cnt_q + {15'd0, wrap_q};
        end
    end

    assign vga.frame_count = frame_cnt_q;
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end;
    assign vga.frame_count  = 16'h0000;
`endif

endmodule
